// File: rtl/seg7_pkg.sv
// Shared constants and hex-to-segment decode for the multiplexed display driver.
// Segment vectors are gfedcba, active-low.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_scan_if.sv
// Capture inputs and display pins of the seg7 scanner.
// The scanner takes the slave side; whoever feeds the counter value and watches the pins is the master.
interface seg7_scan_if;
    logic [3:0] D;
    logic       LD;
    logic       BLANK_LZ;
    logic [3:0] AN;
    logic [6:0] SEG;
    logic       DP;

    modport master (output D, LD, BLANK_LZ, input AN, SEG, DP);
    modport slave  (input D, LD, BLANK_LZ, output AN, SEG, DP);
endinterface

// File: rtl/seg7_dec.sv
// Combinational hex-to-seven-segment decoder for the currently scanned digit.
module seg7_dec
    import seg7_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);
    assign o_seg = hex_to_seg(i_hex);
endmodule

// File: rtl/seg7_scan.sv
// Four-digit history store with time-multiplexed, hex-decoded display scanning.
// Pins are registered: they show the store/index state as it was before each edge.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic        C,
    input  logic        CLR,
    seg7_scan_if.slave  bus
);
    logic [15:0] r_pre;
    logic [1:0]  r_idx;
    logic [3:0]  r_dig [4];
    logic [2:0]  r_vcnt;

    logic        w_tick;
    logic [3:0]  w_blank;
    logic [6:0]  w_seg;

    assign w_tick = (r_pre == 16'(PRESCALE - 1));

    // Walk from the top digit down, tracking whether every loaded digit from here up is zero.
    always_comb begin
        logic v_zero;
        v_zero  = 1'b1;
        w_blank = '0;
        for (int i = 3; i >= 0; i--) begin
            if (3'(i) < r_vcnt) begin
                v_zero = v_zero && (r_dig[i] == 4'd0);
            end
            w_blank[i] = (3'(i) >= r_vcnt) || (bus.BLANK_LZ && (i != 0) && v_zero);
        end
    end

    seg7_dec u_dec (
        .i_hex (r_dig[r_idx]),
        .o_seg (w_seg)
    );

    always_ff @(posedge C) begin
        if (CLR) begin
            r_pre   <= '0;
            r_idx   <= '0;
            r_vcnt  <= '0;
            for (int i = 0; i < 4; i++) begin
                r_dig[i] <= '0;
            end
            bus.AN  <= AN_OFF;
            bus.SEG <= SEG_OFF;
            bus.DP  <= 1'b1;
        end else begin
            r_pre <= w_tick ? 16'd0 : r_pre + 16'd1;
            if (w_tick) begin
                r_idx <= r_idx + 2'd1;
            end
            if (bus.LD) begin
                r_dig[0] <= bus.D;
                for (int i = 1; i < 4; i++) begin
                    r_dig[i] <= r_dig[i-1];
                end
                r_vcnt <= (r_vcnt == 3'd4) ? 3'd4 : r_vcnt + 3'd1;
            end
            if (w_blank[r_idx]) begin
                bus.AN  <= AN_OFF;
                bus.SEG <= SEG_OFF;
            end else begin
                bus.AN  <= ~(4'b0001 << r_idx);
                bus.SEG <= w_seg;
            end
            bus.DP <= !((r_idx == 2'd0) && !w_blank[0]);
        end
    end
endmodule

// File: doc/seg7_scan.md
# seg7_scan

Four-digit multiplexed seven-segment display driver that sits directly downstream of the 4-bit lab counter. It captures the counter's `Q` output on a load strobe into a four-deep digit history, with the newest value on digit 0. It time-multiplexes the digits onto the board's common segment bus, applying hex decoding and optional leading-zero blanking.

## Interface
- `PRESCALE`, default 4: clock cycles per digit slot; legal range 2..65535 (board builds use 50000).
- `C` in 1: clock; all state updates on the rising edge.
- `CLR` in 1: reset, synchronous, active-high.
- `D` in 4: value to capture; driven by the counter's `Q`.
- `LD` in 1: load strobe, one cycle per capture.
- `BLANK_LZ` in 1: leading-zero blanking enable; sampled every cycle.
- `AN` out 4: digit enables, active-low; `AN[i]` drives digit i.
- `SEG` out 7: segments, active-low; `SEG[0]`=a … `SEG[6]`=g.
- `DP` out 1: decimal point, active-low.

## Operation
- Digit store `dig[0..3]` (4 bits each) plus fill count `vcnt` (0..4, saturating).
- On `LD`:
  - `dig[0]<=D`, and `dig[i]<=dig[i-1]` for i=1..3; the oldest value is dropped.
  - `vcnt<=min(vcnt+1,4)`.
- Prescaler `pre` counts 0..PRESCALE-1 and wraps. `tick` is asserted when `pre==PRESCALE-1`.
- Scan index `idx` (2 bits) increments on `tick` and wraps 3→0.
- Digit i is *blank* if either:
  - i ≥ `vcnt` (never loaded), or
  - `BLANK_LZ`=1, i≥1, and `dig[j]==0` for all j with i ≤ j < `vcnt`.
- Digit 0 is never blanked by `BLANK_LZ`.
- For the current `idx`:
  - Not blank: `AN` = ~(1<<idx); `SEG` = hex decode of `dig[idx]`.
  - Blank: `AN`=4'hF; `SEG`=7'h7F.
- `DP`=0 only when idx==0 and digit 0 is not blank; otherwise 1.
- Hex decode (gfedcba, active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.

## Timing
- Reset (`CLR`=1 at an edge):
  - `dig`=0, `vcnt`=0, `pre`=0, `idx`=0.
  - `AN`=4'hF, `SEG`=7'h7F, `DP`=1.
  - `CLR` has priority over `LD` and `tick` in the same cycle.
  - A reset mid-scan empties the store immediately.
- `AN`, `SEG` and `DP` are registered. They reflect `idx`, `dig`, `vcnt` and `BLANK_LZ` as they stood before the same edge, giving 1-cycle latency from a state change to the pins.
- After `CLR` deasserts, the first `tick` falls on the PRESCALE-th edge. Each digit then holds for exactly PRESCALE cycles; a full frame is 4·PRESCALE cycles.
- If `LD` and `tick` occur in the same cycle, both take effect. The next output update shows the new `idx` with the shifted `dig`.
- Back-to-back `LD` shifts every cycle. No handshake; `LD` is never refused.
- `vcnt` saturates at 4. Further loads keep shifting.

## Structure
- Package `seg7_pkg`:
  - `SEG_OFF`=7'h7F and `AN_OFF`=4'hF.
  - `function hex_to_seg(input [3:0])` returning the decode table above.
- Sub-module `seg7_dec`: combinational wrapper around `hex_to_seg`, instantiated once on the selected digit.
- The prescaler, scan index and digit store live in `seg7_scan`.

## Test plan
All scenarios use PRESCALE=4.
1. **Reset:** hold `CLR` 2 cycles, then release with `LD`=0. `AN`=F, `SEG`=7F and `DP`=1 for 16+ cycles (all digits blank).
2. **Single load:** `LD` with `D`=5, `BLANK_LZ`=0.
   - Digit 0 slot: `AN`=E, `SEG`=12, `DP`=0.
   - Digit 1–3 slots: `AN`=F, `SEG`=7F.
3. **Full store:** load 1, 2, 3, A in sequence. Slots show:
   - `AN`=E, `SEG`=08 (digit 0 = A)
   - `AN`=D, `SEG`=30
   - `AN`=B, `SEG`=24
   - `AN`=7, `SEG`=79
   
   Each slot lasts 4 cycles and wraps to digit 0 after `AN`=7. A fifth load of F drops the 1: `AN`=7 slot then shows `SEG`=24.
4. **Leading-zero blanking:** load 0, 0, 7 with `BLANK_LZ`=1. Digit 0 shows 78 and digits 1–3 are blank. With `BLANK_LZ`=0, digits 1–2 show 40.
5. **Simultaneous `LD` and `tick`:** pulse `LD` with `D`=9 on the cycle where `pre`=3. The next edge shows the new index with the updated store.
6. **Reset priority:** assert `CLR` together with `LD` mid-frame. Outputs are F/7F/1 on the next edge, and `vcnt`=0.
